// File: rtl/id_token_collector.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : id_token_collector                                             |
// | Brief   : Measures identifier lengths from an id_fsm flag stream and     |
// |           queues them in a small FIFO. ID_TOKEN_MAXLEN_EN enables the    |
// |           max_len tracker.                                               |
// | Revision: 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module id_token_collector #(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       char,
  input  logic             char_valid,
  input  logic             id_flag,
  output logic [7:0]       len_data,
  output logic             len_valid,
  input  logic             len_ready,
  output logic [CNT_W-1:0] tok_count,
  output logic [7:0]       max_len,
  output logic             drop_err
);

  localparam int c_aw = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [c_aw:0] c_depth = (c_aw+1)'(FIFO_DEPTH);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    IN_ID = 1'b1
  } state_t;

  state_t           r_state;
  logic [7:0]       r_cur_len;
  logic [7:0]       r_mem [FIFO_DEPTH];
  logic [c_aw-1:0]  r_wptr;
  logic [c_aw-1:0]  r_rptr;
  logic [c_aw:0]    r_count;
  logic [CNT_W-1:0] r_tok_count;
  logic             r_drop_err;

  logic w_push_req;
  logic w_pop;
  logic w_full;
  logic w_push_ok;
  logic w_unused_char;

  // The character value itself is irrelevant here; id_fsm already classified it.
  assign w_unused_char = ^char;

  assign w_push_req = char_valid && (r_state == IN_ID) && !id_flag;
  assign w_pop      = len_valid && len_ready;
  assign w_full     = (r_count == c_depth);
  // A full FIFO still accepts a push when the same edge frees a slot.
  assign w_push_ok  = w_push_req && (!w_full || w_pop);

  assign len_valid = (r_count != '0);
  assign len_data  = r_mem[r_rptr];
  assign tok_count = r_tok_count;
  assign drop_err  = r_drop_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_cur_len <= 8'd0;
    end else if (char_valid) begin
      case (r_state)
        IDLE: begin
          if (id_flag) begin
            r_state   <= IN_ID;
            r_cur_len <= 8'd1;
          end
        end
        IN_ID: begin
          if (id_flag) begin
            if (r_cur_len != 8'hFF) r_cur_len <= r_cur_len + 8'd1;
          end else begin
            r_state   <= IDLE;
            r_cur_len <= 8'd0;
          end
        end
        default: begin
          r_state   <= IDLE;
          r_cur_len <= 8'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= 8'd0;
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_tok_count <= '0;
      r_drop_err  <= 1'b0;
    end else begin
      if (w_push_ok) begin
        r_mem[r_wptr] <= r_cur_len;
        r_wptr        <= r_wptr + c_aw'(1);
        r_tok_count   <= r_tok_count + CNT_W'(1);
      end
      if (w_push_req && !w_push_ok) r_drop_err <= 1'b1;
      if (w_pop) r_rptr <= r_rptr + c_aw'(1);
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + (c_aw+1)'(1);
        2'b01:   r_count <= r_count - (c_aw+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef ID_TOKEN_MAXLEN_EN
  logic [7:0] r_max_len;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_max_len <= 8'd0;
    end else if (w_push_ok && (r_cur_len > r_max_len)) begin
      r_max_len <= r_cur_len;
    end
  end

  assign max_len = r_max_len;
`else
  assign max_len = 8'd0;
`endif

endmodule
`default_nettype wire
